cache_mem_bridge: RTL and testbench
===================================

CACHE_MEM_BRIDGE -- requirements
Module: cache_mem_bridge

Interface
REQ-001 Parameter OUTSTANDING, default 4, SHALL set the max accepted-but-unanswered mem requests; legal range 1..4.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 rd_req  in  1  cache read request, accepted when rd_req&&rd_rdy.
REQ-005 rd_type  in  3  010 = single word, 100 = 16-byte line; other codes are illegal.
REQ-006 rd_addr  in  32  read byte address; line reads use [31:4].
REQ-007 rd_rdy  out  1  read slot empty.
REQ-008 ret_valid  out  1  one returned read word this cycle.
REQ-009 ret_last  out  1  final word of current read; asserted only with ret_valid.
REQ-010 ret_data  out  32  returned word.
REQ-011 wr_req  in  1  cache write request; the cache asserts it only while wr_rdy=1, so it is always accepted.
REQ-012 wr_type  in  3  010 = single word, 100 = line.
REQ-013 wr_addr  in  32  write byte address.
REQ-014 wr_wstrb  in  4  byte enables, single-word write only.
REQ-015 wr_data  in  128  line data; word i at [32i+31:32i].
REQ-016 wr_rdy  out  1  write buffer empty; independent of wr_req.
REQ-017 mem_req  out  1  word request valid.
REQ-018 mem_wr  out  1  1 = write, 0 = read.
REQ-019 mem_addr  out  32  word address, [1:0]=0.
REQ-020 mem_wstrb  out  4  write byte enables.
REQ-021 mem_wdata  out  32  write word.
REQ-022 mem_addr_ok  in  1  request accepted when mem_req&&mem_addr_ok.
REQ-023 mem_data_ok  in  1  one in-order response per accepted request, reads and writes alike.
REQ-024 mem_rdata  in  32  read response data.

Function
REQ-025 SHALL hold one read slot (type, addr) and one write buffer (type, addr, 128-bit data, wstrb); both SHALL accept in the same cycle.
REQ-026 Line access SHALL issue 4 words at {addr[31:4], 4'h0}+0/4/8/12 in that order; write strobes SHALL be 4'hf.
REQ-027 Word write SHALL issue 1 request at {wr_addr[31:2],2'b0} with wr_wstrb and data wr_data[32*wr_addr[3:2]+:32].
REQ-028 Word read SHALL issue 1 request; its response SHALL raise ret_valid and ret_last together.
REQ-029 Issue FSM states: IDLE, WR_ISSUE, RD_ISSUE. A request is held stable until mem_addr_ok; the word counter (2 bits) SHALL advance only on acceptance.
REQ-030 mem_req SHALL be 0 when the outstanding counter equals OUTSTANDING, unless mem_data_ok retires one in the same cycle.
REQ-031 A 1-bit type FIFO of depth OUTSTANDING SHALL record each accepted request; on mem_data_ok the head SHALL be popped, with write responses dropped and read responses forwarded.
REQ-032 ret_valid/ret_data SHALL be registered: one cycle after the mem_data_ok of a read response.
REQ-033 ret_last SHALL mark the 4th line word or the single word; the read slot SHALL free, and rd_rdy SHALL rise, in that same cycle.
REQ-034 The write buffer SHALL free after the last write word is accepted; it SHALL NOT wait for write responses.
REQ-035 Simultaneous push and pop on the type FIFO or the counter SHALL leave its occupancy unchanged.

Reset
REQ-036 While resetn=0: FSM=IDLE, counters and FIFO empty, slots empty; mem_req, ret_valid, ret_last, rd_rdy, wr_rdy SHALL be 0; data outputs SHALL be 0.
REQ-037 Reset mid-burst SHALL discard all pending work; the mem side SHALL be reset concurrently, and responses arriving after reset are unsupported.

Configuration
REQ-038 Macro BRIDGE_RD_FIRST_EN defined: a pending read SHALL issue before a pending write, unless rd_addr[31:4]==write-buffer addr[31:4], in which case the write drains first.
REQ-039 Macro undefined: a pending write SHALL always drain completely before any read word issues.

Verification
REQ-040 Line read at 0x1C00_0010, mem_addr_ok=1, data_ok 2 cycles later -> mem_addr 0x..10/14/18/1C; 4 ret_valid beats; ret_last on the 4th beat only.
REQ-041 Line write at 0x0000_0040 and line read at 0x0000_0080 in the same cycle, macro undefined -> 4 writes (wstrb f) precede 4 reads; only read data is returned.
REQ-042 Word write wr_addr=0xBFAF_F028, wstrb=4'b0011 -> mem_addr 0xBFAF_F028, mem_wdata=wr_data[95:64], mem_wstrb=3.
REQ-043 OUTSTANDING=2, data_ok withheld 10 cycles -> exactly 2 accepted, mem_req low until the first data_ok.
REQ-044 Macro defined, write line 0x100 pending, read 0x104 -> write drains first; read 0x200 -> read issues first.
REQ-045 resetn pulsed low during the 3rd word of a line read -> all outputs 0 immediately; after release rd_rdy=wr_rdy=1 and a new read completes normally.

Source files
------------

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: cache read/write slots to a split addr_ok/data_ok word bus.
// Define BRIDGE_RD_FIRST_EN to let reads bypass a pending write to another line.
module cache_mem_bridge #(
  parameter int OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         mem_req,
  output logic         mem_wr,
  output logic [31:0]  mem_addr,
  output logic [3:0]   mem_wstrb,
  output logic [31:0]  mem_wdata,
  input  logic         mem_addr_ok,
  input  logic         mem_data_ok,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE} state_t;

  localparam logic [2:0] MAX = 3'(OUTSTANDING);

  state_t       state, state_nxt;
  logic [1:0]   cnt;
  logic         rd_valid, rd_sent, rd_line;
  logic [31:2]  rd_addr_q;
  logic         wr_valid, wr_line;
  logic [31:2]  wr_addr_q;
  logic [127:0] wr_data_q;
  logic [3:0]   wr_strb_q;
  logic [2:0]   out_cnt;
  logic [3:0]   fifo_q, fifo_nxt;
  logic [1:0]   ret_cnt, widx, push_idx;
  logic         acc, last_word, can_issue;
  logic         push, pop, rd_rsp, ret_done;
  logic         rd_pend, hazard;
  logic         unused_addr;

  assign unused_addr = ^{rd_addr[1:0], wr_addr[1:0]};

  assign rd_rdy    = resetn & ~rd_valid;
  assign wr_rdy    = resetn & ~wr_valid;
  assign pop       = mem_data_ok & (out_cnt != 3'd0);
  assign can_issue = (out_cnt != MAX) | pop;
  assign acc       = mem_req & mem_addr_ok;
  assign push      = acc;
  assign rd_rsp    = pop & ~fifo_q[0];
  assign ret_done  = rd_rsp & (~rd_line | (ret_cnt == 2'd3));
  assign rd_pend   = rd_valid & ~rd_sent;
  assign hazard    = wr_valid & (rd_addr_q[31:4] == wr_addr_q[31:4]);
  assign push_idx  = out_cnt[1:0] - {1'b0, pop};

  // Drive the current bus word from the active slot
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    last_word = 1'b0;
    widx      = wr_line ? cnt : wr_addr_q[3:2];
    unique case (state)
      WR_ISSUE: begin
        mem_req   = can_issue;
        mem_wr    = 1'b1;
        mem_wdata = wr_data_q[{widx, 5'b0} +: 32];
        if (wr_line) begin
          mem_addr  = {wr_addr_q[31:4], cnt, 2'b00};
          mem_wstrb = 4'hf;
          last_word = (cnt == 2'd3);
        end else begin
          mem_addr  = {wr_addr_q, 2'b00};
          mem_wstrb = wr_strb_q;
          last_word = 1'b1;
        end
      end
      RD_ISSUE: begin
        mem_req = can_issue;
        if (rd_line) begin
          mem_addr  = {rd_addr_q[31:4], cnt, 2'b00};
          last_word = (cnt == 2'd3);
        end else begin
          mem_addr  = {rd_addr_q, 2'b00};
          last_word = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pick the next slot to serve and return to idle after its last word
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
`ifdef BRIDGE_RD_FIRST_EN
        if (rd_pend && !hazard)
          state_nxt = RD_ISSUE;
        else if (wr_valid)
          state_nxt = WR_ISSUE;
`else
        if (wr_valid)
          state_nxt = WR_ISSUE;
        else if (rd_pend)
          state_nxt = RD_ISSUE;
`endif
      end
      WR_ISSUE, RD_ISSUE:
        if (acc && last_word)
          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue state and word counter, stepping only on acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (acc)
        cnt <= last_word ? 2'd0 : cnt + 2'd1;
    end
  end

  // Read slot: held until its final word is returned
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid  <= 1'b0;
      rd_sent   <= 1'b0;
      rd_line   <= 1'b0;
      rd_addr_q <= '0;
    end else if (rd_req && rd_rdy) begin
      rd_valid  <= 1'b1;
      rd_sent   <= 1'b0;
      rd_line   <= (rd_type == 3'b100);
      rd_addr_q <= rd_addr[31:2];
    end else begin
      if (state == RD_ISSUE && acc && last_word)
        rd_sent <= 1'b1;
      if (ret_done)
        rd_valid <= 1'b0;
    end
  end

  // Write buffer: freed once its last word is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_valid  <= 1'b0;
      wr_line   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= 4'h0;
    end else if (wr_req && wr_rdy) begin
      wr_valid  <= 1'b1;
      wr_line   <= (wr_type == 3'b100);
      wr_addr_q <= wr_addr[31:2];
      wr_data_q <= wr_data;
      wr_strb_q <= wr_wstrb;
    end else if (state == WR_ISSUE && acc && last_word) begin
      wr_valid <= 1'b0;
    end
  end

  // Type FIFO next value: shift out the head, append at the tail
  always_comb begin
    fifo_nxt = pop ? (fifo_q >> 1) : fifo_q;
    if (push)
      fifo_nxt[push_idx] = mem_wr;
  end

  // Outstanding tracking: occupancy and per-request type
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_cnt <= 3'd0;
      fifo_q  <= 4'h0;
    end else begin
      out_cnt <= out_cnt + {2'b0, push} - {2'b0, pop};
      fifo_q  <= fifo_nxt;
    end
  end

  // Registered return path for read responses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= 32'h0;
      ret_cnt   <= 2'd0;
    end else begin
      ret_valid <= rd_rsp;
      ret_last  <= ret_done;
      if (rd_rsp) begin
        ret_data <= mem_rdata;
        ret_cnt  <= ret_done ? 2'd0 : ret_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: random and directed traffic against a memory model.
// Expected bus words and returned data come from the bench's own rules.
module tb_cache_mem_bridge;

  localparam int OUTS = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'b010;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy;
  logic         ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'b010;
  logic [31:0]  wr_addr = '0;
  logic [3:0]   wr_wstrb = '0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy;
  logic         mem_req, mem_wr;
  logic [31:0]  mem_addr, mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_addr_ok = 1'b0;
  logic         mem_data_ok = 1'b0;
  logic [31:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  cache_mem_bridge #(.OUTSTANDING(OUTS)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  typedef struct {logic [31:0] a; logic [3:0] s; logic [31:0] d;} wr_t;
  typedef struct {bit wr; logic [31:0] d; int due;} rsp_t;
  typedef struct {bit wr; logic [31:0] a;} log_t;
  typedef struct {logic [31:0] d; bit last;} ret_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_ra[$];
  bit          exp_last[$];
  rsp_t        rsp_q[$];
  log_t        log_q[$];
  ret_t        exp_ret[$];
  logic [31:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 2;
  int beats = 0;
  int lasts = 0;
  bit ok_always = 0;
  bit fixed_lat = 0;
  bit hold_dok = 0;
  bit prev_rd = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // memory responder: drives handshakes just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    mem_addr_ok = ok_always || ($urandom % 3 != 0);
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc && !hold_dok &&
        (fixed_lat || $urandom % 4 != 0)) begin
      mem_data_ok = 1'b1;
      mem_rdata   = rsp_q[0].d;
    end else begin
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
    end
  end

  // monitor: observes every handshake on the falling edge
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      prev_rd = 0;
      continue;
    end
    check("ret_last_nv", ret_last & ~ret_valid, 1'b0);
    if (ret_valid || prev_rd) begin
      check("ret_vld", ret_valid, prev_rd);
      if (ret_valid) begin
        beats++;
        if (ret_last) lasts++;
        if (exp_ret.size() == 0) begin
          check("ret_extra", ret_valid, 1'b0);
        end else begin
          ret_t e;
          e = exp_ret.pop_front();
          check("ret", {ret_data, ret_last}, {e.d, e.last});
        end
      end
    end
    prev_rd = 0;
    if (mem_data_ok && rsp_q.size() > 0) begin
      rsp_t r;
      r = rsp_q.pop_front();
      if (!r.wr) begin
        ret_t e;
        prev_rd = 1;
        e.d = r.d;
        e.last = (exp_last.size() > 0) ? exp_last.pop_front() : 1'b0;
        exp_ret.push_back(e);
      end
    end
    if (mem_req && mem_addr_ok) begin
      rsp_t r;
      log_t l;
      l.wr = mem_wr;
      l.a = mem_addr;
      log_q.push_back(l);
      r.wr = mem_wr;
      r.d = 32'h0;
      r.due = cyc + (fixed_lat ? lat : int'($urandom_range(1, 6)));
      if (mem_wr) begin
        wr_t e;
        logic [31:0] m;
        e = (exp_wr.size() > 0) ? exp_wr.pop_front() : '{32'hx, 4'hx, 32'hx};
        check("mem_wr", {mem_addr, mem_wstrb, mem_wdata}, {e.a, e.s, e.d});
        m = rd_mem(e.a);
        for (int b = 0; b < 4; b++)
          if (e.s[b]) m[8*b +: 8] = e.d[8*b +: 8];
        mem[e.a] = m;
      end else begin
        logic [31:0] ea;
        ea = (exp_ra.size() > 0) ? exp_ra.pop_front() : 32'hx;
        check("mem_rd_addr", mem_addr, ea);
        r.d = rd_mem(ea);
      end
      rsp_q.push_back(r);
    end
    if (rd_req && rd_rdy) begin
      if (rd_type == 3'b100) begin
        for (int i = 0; i < 4; i++) begin
          exp_ra.push_back({rd_addr[31:4], 4'h0} + 32'(4 * i));
          exp_last.push_back(i == 3);
        end
      end else begin
        exp_ra.push_back({rd_addr[31:2], 2'b00});
        exp_last.push_back(1'b1);
      end
    end
    if (wr_req && wr_rdy) begin
      if (wr_type == 3'b100) begin
        for (int i = 0; i < 4; i++)
          exp_wr.push_back('{{wr_addr[31:4], 4'h0} + 32'(4 * i),
                             4'hf, wr_data[32*i +: 32]});
      end else begin
        exp_wr.push_back('{{wr_addr[31:2], 2'b00}, wr_wstrb,
                           wr_data[32*int'(wr_addr[3:2]) +: 32]});
      end
    end
  end

  task automatic send(bit dr, bit rl, logic [31:0] ra,
                      bit dw, bit wl, logic [31:0] wa,
                      logic [3:0] ws, logic [127:0] wd);
    int t = 0;
    while (((dr && !rd_rdy) || (dw && !wr_rdy)) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 400) check("send_timeout", t, 0);
    rd_req = dr;
    rd_type = rl ? 3'b100 : 3'b010;
    rd_addr = ra;
    wr_req = dw;
    wr_type = wl ? 3'b100 : 3'b010;
    wr_addr = wa;
    wr_wstrb = ws;
    wr_data = wd;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (!(rd_rdy && wr_rdy && !mem_req && rsp_q.size() == 0 &&
             exp_ret.size() == 0) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) check("drain_timeout", t, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(string tag);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_ret_valid"}, ret_valid, 1'b0);
    check({tag, "_ret_last"}, ret_last, 1'b0);
    check({tag, "_rd_rdy"}, rd_rdy, 1'b0);
    check({tag, "_wr_rdy"}, wr_rdy, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, {mem_wdata, mem_wstrb}, 36'h0);
    check({tag, "_ret_data"}, ret_data, 32'h0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_model();
    exp_wr.delete();
    exp_ra.delete();
    exp_last.delete();
    rsp_q.delete();
    exp_ret.delete();
    log_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit rd_first;
`ifdef BRIDGE_RD_FIRST_EN
    rd_first = 1;
`else
    rd_first = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs("rst");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_rdy", {rd_rdy, wr_rdy}, 2'b11);

    ok_always = 1;
    fixed_lat = 1;
    lat = 2;
    log_q.delete();
    beats = 0;
    lasts = 0;
    send(1, 1, 32'h1C00_0010, 0, 0, 32'h0, 4'h0, '0);
    drain();
    check("line_rd_n", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      check("line_rd_addr", {log_q[i].wr, log_q[i].a},
            {1'b0, 32'h1C00_0010 + 32'(4 * i)});
    check("line_rd_beats", beats, 4);
    check("line_rd_lasts", lasts, 1);

    log_q.delete();
    beats = 0;
    send(1, 1, 32'h0000_0080, 1, 1, 32'h0000_0040, 4'h0, rnd128());
    drain();
    check("rw_n", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      bit wr_slot;
      wr_slot = rd_first ? (i >= 4) : (i < 4);
      check("rw_order", {log_q[i].wr, log_q[i].a},
            {wr_slot, (wr_slot ? 32'h40 : 32'h80) + 32'(4 * (i % 4))});
    end
    check("rw_beats", beats, 4);

    log_q.delete();
    send(0, 0, 32'h0, 1, 0, 32'hBFAF_F028, 4'b0011, rnd128());
    drain();
    check("wword_n", log_q.size(), 1);
    if (log_q.size() > 0)
      check("wword_addr", {log_q[0].wr, log_q[0].a}, {1'b1, 32'hBFAF_F028});

    log_q.delete();
    send(1, 0, 32'h0000_0104, 1, 1, 32'h0000_0100, 4'h0, rnd128());
    drain();
    check("haz_n", log_q.size(), 5);
    if (log_q.size() == 5)
      check("haz_order", {log_q[0].wr, log_q[4].wr, log_q[4].a},
            {2'b10, 32'h104});

    log_q.delete();
    send(1, 0, 32'h0000_0200, 1, 1, 32'h0000_0300, 4'h0, rnd128());
    drain();
    check("nohaz_n", log_q.size(), 5);
    if (log_q.size() == 5)
      check("nohaz_first", {log_q[0].wr, log_q[0].a},
            rd_first ? {1'b0, 32'h200} : {1'b1, 32'h300});

    log_q.delete();
    hold_dok = 1;
    send(1, 1, 32'h0000_0400, 0, 0, 32'h0, 4'h0, '0);
    repeat (10) @(posedge clk);
    #1;
    check("outs_accepted", log_q.size(), OUTS);
    check("outs_req_low", mem_req, 1'b0);
    hold_dok = 0;
    t = 0;
    while (log_q.size() <= OUTS && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("outs_resume", log_q.size() > OUTS, 1'b1);
    drain();

    ok_always = 0;
    fixed_lat = 0;
    for (int n = 0; n < 80; n++) begin
      int k;
      logic [31:0] ra, wa;
      k = $urandom % 3;
      ra = 32'h1000 + 32'(($urandom % 8) * 16) + 32'(($urandom % 4) * 4);
      wa = 32'h1000 + 32'(($urandom % 8) * 16) + 32'(($urandom % 4) * 4);
      send(k != 1, $urandom % 2, ra, k != 0, $urandom % 2, wa,
           4'($urandom), rnd128());
      repeat ($urandom % 4) @(posedge clk);
      #1;
    end
    drain();

    ok_always = 1;
    fixed_lat = 1;
    lat = 3;
    log_q.delete();
    send(1, 1, 32'h0000_0500, 0, 0, 32'h0, 4'h0, '0);
    t = 0;
    while (log_q.size() < 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("mid_burst_reached", log_q.size(), 2);
    resetn = 1'b0;
    #1;
    check_idle_outs("mid_rst");
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_rdy", {rd_rdy, wr_rdy}, 2'b11);
    beats = 0;
    lasts = 0;
    send(1, 0, 32'h1C00_0020, 0, 0, 32'h0, 4'h0, '0);
    drain();
    check("post_rst_n", log_q.size(), 1);
    check("post_rst_ret", {beats[7:0], lasts[7:0]}, {8'd1, 8'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
